mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between the instruction-fetch

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port fixed-latency memory.
// Optional ARB_STARVE_GUARD_EN lets a waiting fetch win after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_access,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_access,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1) begin : g_lat_chk
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
        if (STARVE_MAX < 1) begin : g_starve_chk
            $error("mem_port_arbiter: STARVE_MAX must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_nx;
    logic [LAT_W-1:0] lat_cnt;
    logic             own_d;
    logic             we_q;
    logic             fetch_wins;
    logic             last_cyc;

    assign last_cyc = (lat_cnt == LAT_W'(MEM_LAT - 1));

`ifdef ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (if_gnt || (state == IDLE && !if_req))
            starve_cnt <= '0;
        else if (d_gnt && if_req && starve_cnt != SC_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign fetch_wins = if_req && (!d_req || starve_cnt == SC_W'(STARVE_MAX));
`else
    assign fetch_wins = if_req && !d_req;
`endif

    // Grants are held off while reset is asserted so every output reads 0.
    always_comb begin
        state_nx = state;
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        case (state)
            IDLE: if (rst && (if_req || d_req)) begin
                state_nx = BUSY;
                if_gnt   = fetch_wins;
                d_gnt    = !fetch_wins;
            end
            BUSY:    if (last_cyc) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            own_d      <= 1'b0;
            we_q       <= 1'b0;
            mem_access <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nx;
            if (state == BUSY)
                lat_cnt <= last_cyc ? '0 : lat_cnt + 1'b1;
            if (if_gnt) begin
                own_d      <= 1'b0;
                we_q       <= 1'b0;
                mem_access <= 3'b010;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
            end else if (d_gnt) begin
                own_d      <= 1'b1;
                we_q       <= d_we;
                mem_access <= d_access;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
            end
            // Read data is only valid on the final BUSY cycle; stores return 0.
            if (state == BUSY && last_cyc) begin
                if (!own_d)
                    if_rdata <= mem_rdata;
                else
                    d_rdata <= we_q ? '0 : mem_rdata;
            end
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = mem_req && we_q;
    assign busy      = (state != IDLE);
    assign if_rvalid = (state == RESP) && !own_d;
    assign d_rvalid  = (state == RESP) && own_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random traffic
// against a timestamp-based transaction model.
module tb_mem_port_arbiter;
    localparam int L    = 3;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]  d_access;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, busy;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_access(mem_access),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // Transaction model: a grant at cycle g occupies cycles g+1..g+L+1 and frees at g+L+2.
    int          cyc, free_at, g, starve, mcnt;
    bit          own_d, cur_we;
    logic [2:0]  cur_acc;
    logic [31:0] cur_addr, cur_wd, e_ird, e_drd;
    bit          got_ign, got_dgn, got_mwe;
    logic [31:0] got_maddr;
    logic [2:0]  got_macc;

    task automatic model_reset();
        free_at = cyc; g = -100; starve = 0; mcnt = 0;
        own_d = 0; cur_we = 0; cur_acc = 0; cur_addr = 0; cur_wd = 0;
        e_ird = 0; e_drd = 0;
    endtask

    // Called just after a falling edge with inputs set; checks this cycle, ends at next falling edge.
    task automatic step();
        bit idle, e_mreq, e_rsp, fw, e_ign, e_dgn;
        #1;
        idle   = (cyc >= free_at);
        e_mreq = !idle && cyc > g && cyc <= g + L;
        e_rsp  = !idle && cyc == g + L + 1;
        if (e_rsp) begin
            if (own_d) e_drd = cur_we ? 32'h0 : mem_word(cur_addr);
            else       e_ird = mem_word(cur_addr);
        end
        fw    = idle && if_req && (!d_req || (GUARD && starve == SMAX));
        e_ign = fw;
        e_dgn = idle && d_req && !fw;
        chk("if_gnt", if_gnt, e_ign);
        chk("d_gnt", d_gnt, e_dgn);
        chk("busy", busy, !idle);
        chk("mem_req", mem_req, e_mreq);
        chk("mem_we", mem_we, e_mreq && cur_we);
        chk("if_rvalid", if_rvalid, e_rsp && !own_d);
        chk("d_rvalid", d_rvalid, e_rsp && own_d);
        chk("if_rdata", if_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        if (e_mreq) begin
            chk("mem_addr", mem_addr, cur_addr);
            chk("mem_access", mem_access, cur_acc);
            if (cur_we) chk("mem_wdata", mem_wdata, cur_wd);
        end
        got_ign = if_gnt; got_dgn = d_gnt;
        got_maddr = mem_addr; got_mwe = mem_we; got_macc = mem_access;
        if (e_ign || e_dgn) begin
            g        = cyc;
            free_at  = cyc + L + 2;
            own_d    = e_dgn;
            cur_we   = e_dgn && d_we;
            cur_acc  = e_dgn ? d_access : 3'b010;
            cur_addr = e_dgn ? d_addr : if_addr;
            cur_wd   = d_wdata;
        end
        if (e_ign)                               starve = 0;
        else if (idle && !if_req)                starve = 0;
        else if (e_dgn && if_req && starve < SMAX) starve++;
        // Memory: data is valid only in the L-th consecutive cycle of mem_req.
        if (mem_req) begin
            mcnt++;
            mem_rdata = (mcnt == L) ? mem_word(mem_addr) : $urandom;
        end else begin
            mcnt = 0;
            mem_rdata = $urandom;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic zero_chk(input string pfx);
        chk({pfx, "_if_gnt"}, if_gnt, 0);
        chk({pfx, "_d_gnt"}, d_gnt, 0);
        chk({pfx, "_if_rvalid"}, if_rvalid, 0);
        chk({pfx, "_d_rvalid"}, d_rvalid, 0);
        chk({pfx, "_if_rdata"}, if_rdata, 0);
        chk({pfx, "_d_rdata"}, d_rdata, 0);
        chk({pfx, "_mem_req"}, mem_req, 0);
        chk({pfx, "_mem_we"}, mem_we, 0);
        chk({pfx, "_mem_access"}, mem_access, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          we;
        logic [2:0]  acc;
        logic [31:0] da;
        logic [31:0] wd;
        bit          x_ign;
        bit          x_dgn;
        logic [31:0] x_addr;
        bit          x_we;
        logic [2:0]  x_acc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_i, n_d, budget;
        tbl[0] = '{1, 32'h10,       0, 0, 3'b000, 32'h0,    32'h0,      1, 0, 32'h10,       0, 3'b010};
        tbl[1] = '{1, 32'h20,       1, 0, 3'b010, 32'h200,  32'h0,      0, 1, 32'h200,      0, 3'b010};
        tbl[2] = '{0, 32'h0,        1, 1, 3'b001, 32'h44,   32'hBEEF,   0, 1, 32'h44,       1, 3'b001};
        tbl[3] = '{0, 32'h0,        1, 0, 3'b100, 32'h1000, 32'h0,      0, 1, 32'h1000,     0, 3'b100};
        tbl[4] = '{1, 32'hFFFFFFFC, 0, 1, 3'b111, 32'h88,   32'h5555,   1, 0, 32'hFFFFFFFC, 0, 3'b010};
        tbl[5] = '{1, 32'h30,       1, 1, 3'b000, 32'h8,    32'hA5A5A5, 0, 1, 32'h8,        1, 3'b000};

        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_access = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0;
        #2;
        zero_chk("reset");
        @(negedge clk); @(negedge clk);
        rst = 1;
        cyc = 0;
        model_reset();

        // Vector table: single grants from IDLE.
        foreach (tbl[i]) begin
            if_req = tbl[i].ir; if_addr = tbl[i].ia; d_req = tbl[i].dr; d_we = tbl[i].we;
            d_access = tbl[i].acc; d_addr = tbl[i].da; d_wdata = tbl[i].wd;
            step();
            chk("tbl_if_gnt", got_ign, tbl[i].x_ign);
            chk("tbl_d_gnt", got_dgn, tbl[i].x_dgn);
            if_req = 0; d_req = 0;
            step();
            chk("tbl_mem_addr", got_maddr, tbl[i].x_addr);
            chk("tbl_mem_we", got_mwe, tbl[i].x_we);
            chk("tbl_mem_access", got_macc, tbl[i].x_acc);
            repeat (L) step();
        end

        // Both request: data wins, held fetch granted at T+L+2.
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_access = 3'b010; d_addr = 32'h200;
        step();
        chk("both_d_gnt", got_dgn, 1);
        d_req = 0;
        repeat (L + 1) step();
        step();
        chk("held_fetch_gnt", got_ign, 1);
        if_req = 0;
        repeat (L + 1) step();

        // Request raised during RESP waits for the following IDLE cycle.
        if_req = 1; if_addr = 32'h100;
        step();
        if_req = 0;
        repeat (L) step();
        d_req = 1; d_we = 0; d_addr = 32'h300; d_access = 3'b010;
        step();
        chk("resp_no_gnt", got_dgn, 0);
        step();
        chk("idle_after_resp_gnt", got_dgn, 1);
        d_req = 0;
        repeat (L + 1) step();

        // Both held continuously: fetch only gets in through the starvation guard.
        if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500;
        n_i = 0; n_d = 0; budget = 0;
        while (n_i + n_d < 10 && budget < 200) begin
            step();
            budget++;
            if (got_ign) n_i++;
            if (got_dgn) n_d++;
        end
        chk("starve_budget", budget < 200, 1);
        chk("starve_fetch_grants", n_i, GUARD ? 2 : 0);
        if_req = 0; d_req = 0;
        repeat (L + 2) step();

        // Reset in the second BUSY cycle: access dropped, held request served after release.
        d_req = 1; d_we = 0; d_addr = 32'h600;
        step();
        d_req = 0; if_req = 1; if_addr = 32'h40;
        step();
        rst = 0;
        #1;
        zero_chk("midrst");
        @(negedge clk);
        rst = 1;
        cyc++;
        model_reset();
        step();
        chk("post_rst_gnt", got_ign, 1);
        if_req = 0;
        repeat (L + 1) step();

        // Random traffic with protocol-abiding requesters.
        for (int n = 0; n < 800; n++) begin
            if (if_req && got_ign) if_req = 0;
            else if (if_req && $urandom_range(0, 40) == 0) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req && got_dgn) d_req = 0;
            else if (d_req && $urandom_range(0, 40) == 0) d_req = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_access = $urandom_range(0, 7);
                d_addr = $urandom; d_wdata = $urandom;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
